// File: rtl/beehive_rx_frame_buffer.sv
// beehive_rx_frame_buffer: store-and-forward RX stage between the Corundum AXIS
// receive path and the Beehive MAC-side receive interface. A frame is buffered
// whole so its byte count is known on the startframe beat, then replayed
// big-endian (byte 0 in the top byte lane).
// Optional feature macro: BEEHIVE_RX_FRAME_DROP_EN (drop frames on RAM overflow
// instead of stalling tready; rx_drop_cnt counts dropped frames).
//
// Read FSM states:
//   state    | meaning
//   S_IDLE   | waiting for a queued length entry; pops it and loads the first beat
//   S_STREAM | loading the remaining beats of the current frame into the output reg

`ifndef MAC_INTERFACE_W
`define MAC_INTERFACE_W 512
`endif
`ifndef MTU_SIZE_W
`define MTU_SIZE_W 16
`endif
`ifndef MAC_PADBYTES_W
`define MAC_PADBYTES_W 6
`endif

module beehive_rx_frame_buffer #(
  parameter int AXIS_SYNC_DATA_WIDTH    = 512,
  parameter int AXIS_SYNC_KEEP_WIDTH    = AXIS_SYNC_DATA_WIDTH/8,
  parameter int AXIS_SYNC_RX_USER_WIDTH = -1,
  parameter int DATA_FIFO_DEPTH         = 64,
  parameter int LEN_FIFO_DEPTH          = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               app_axis_sync_rx_tvalid,
  output logic                               app_axis_sync_rx_tready,
  input  logic [AXIS_SYNC_DATA_WIDTH-1:0]    app_axis_sync_rx_tdata,
  input  logic [AXIS_SYNC_KEEP_WIDTH-1:0]    app_axis_sync_rx_tkeep,
  input  logic                               app_axis_sync_rx_tlast,
  input  logic [AXIS_SYNC_RX_USER_WIDTH-1:0] app_axis_sync_rx_tuser,
  output logic                               convert_dst_rx_val,
  input  logic                               dst_convert_rx_rdy,
  output logic [`MAC_INTERFACE_W-1:0]        convert_dst_rx_data,
  output logic                               convert_dst_rx_startframe,
  output logic [`MTU_SIZE_W-1:0]             convert_dst_rx_frame_size,
  output logic                               convert_dst_rx_endframe,
  output logic [`MAC_PADBYTES_W-1:0]         convert_dst_rx_padbytes,
  output logic [31:0]                        rx_drop_cnt
);

  localparam int DW  = AXIS_SYNC_DATA_WIDTH;
  localparam int KW  = AXIS_SYNC_KEEP_WIDTH;
  localparam int AW  = $clog2(DATA_FIFO_DEPTH);
  localparam int LAW = $clog2(LEN_FIFO_DEPTH);
  localparam int SW  = `MTU_SIZE_W;
  localparam int PW  = `MAC_PADBYTES_W;
  localparam int CW  = $clog2(KW) + 1;
  localparam int KSH = $clog2(KW);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  logic [DW-1:0]      data_mem [DATA_FIFO_DEPTH];
  logic [SW+PW-1:0]   len_mem  [LEN_FIFO_DEPTH];

  logic [AW:0]  wr_ptr_q, wr_ptr_d, commit_q, commit_d, rd_ptr_q, rd_ptr_d;
  logic [LAW:0] len_wr_q, len_wr_d, len_rd_q, len_rd_d;
  logic [SW-1:0] frame_bytes_q, frame_bytes_d;
  logic data_full_q, len_full_q, init_q;
  logic wr_fire, discard, mem_we, len_push, len_empty, out_free, load, pop, keep_ok;
  logic [CW-1:0] keep_cnt;
  logic [DW-1:0] wr_word, rd_data;
  logic [SW+PW-1:0] len_entry, head;
  logic [SW:0] beats_full;
  logic [SW-1:0] head_size, head_beats;
  logic [PW-1:0] head_pad;

  state_t state_q;
  logic val_q, start_q, end_q;
  logic [DW-1:0] data_q;
  logic [SW-1:0] size_q, beats_q;
  logic [PW-1:0] pad_q, frame_pad_q;

  logic unused_tuser;
  assign unused_tuser = ^app_axis_sync_rx_tuser;

`ifdef BEEHIVE_RX_FRAME_DROP_EN
  logic dropping_q, dropping_d;
  logic [31:0] drop_cnt_q, drop_cnt_d;
  assign app_axis_sync_rx_tready = init_q & ~len_full_q;
  assign rx_drop_cnt = drop_cnt_q;
`else
  assign app_axis_sync_rx_tready = init_q & ~len_full_q & ~data_full_q;
  assign rx_drop_cnt = '0;
`endif

  assign wr_fire = app_axis_sync_rx_tvalid & app_axis_sync_rx_tready;

  // Byte count of the beat and byte reversal into big-endian lane order
  always_comb begin
    keep_cnt = '0;
    wr_word  = '0;
    for (int i = 0; i < KW; i++) begin
      keep_cnt = keep_cnt + CW'(app_axis_sync_rx_tkeep[i]);
      wr_word[DW-1-8*i -: 8] = app_axis_sync_rx_tdata[8*i +: 8];
    end
  end

  // Input framing rule: full keep mid-frame, nonzero contiguous keep on the last beat
  always_comb begin
    if (app_axis_sync_rx_tlast)
      keep_ok = (app_axis_sync_rx_tkeep != '0) &&
                ((app_axis_sync_rx_tkeep & (app_axis_sync_rx_tkeep + KW'(1))) == '0);
    else
      keep_ok = &app_axis_sync_rx_tkeep;
  end

  a_keep_rule: assert property (@(posedge clk) disable iff (rst) wr_fire |-> keep_ok);

  assign len_entry = {frame_bytes_q + SW'(keep_cnt), PW'(CW'(KW) - keep_cnt)};

  // Write side: RAM write, byte accumulation, commit and (optionally) drop/rollback
  always_comb begin
    mem_we        = 1'b0;
    len_push      = 1'b0;
    wr_ptr_d      = wr_ptr_q;
    commit_d      = commit_q;
    frame_bytes_d = frame_bytes_q;
`ifdef BEEHIVE_RX_FRAME_DROP_EN
    dropping_d = dropping_q;
    drop_cnt_d = drop_cnt_q;
    discard    = dropping_q | data_full_q;
`else
    discard    = 1'b0;
`endif
    if (wr_fire && discard) begin
`ifdef BEEHIVE_RX_FRAME_DROP_EN
      if (app_axis_sync_rx_tlast) begin
        wr_ptr_d      = commit_q;
        frame_bytes_d = '0;
        dropping_d    = 1'b0;
        drop_cnt_d    = drop_cnt_q + 32'd1;
      end else begin
        dropping_d = 1'b1;
      end
`endif
    end else if (wr_fire) begin
      mem_we   = 1'b1;
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (app_axis_sync_rx_tlast) begin
        len_push      = 1'b1;
        frame_bytes_d = '0;
        commit_d      = wr_ptr_q + 1'b1;
      end else begin
        frame_bytes_d = frame_bytes_q + SW'(keep_cnt);
      end
    end
  end

  // Read-side handshake and pointer advance
  always_comb begin
    len_empty  = (len_wr_q == len_rd_q);
    out_free   = ~val_q | dst_convert_rx_rdy;
    pop        = (state_q == S_IDLE) && !len_empty && out_free;
    load       = pop || ((state_q == S_STREAM) && out_free);
    rd_data    = data_mem[rd_ptr_q[AW-1:0]];
    head       = len_mem[len_rd_q[LAW-1:0]];
    head_size  = head[SW+PW-1:PW];
    head_pad   = head[PW-1:0];
    beats_full = ({1'b0, head_size} + (SW+1)'(KW-1)) >> KSH;
    head_beats = beats_full[SW-1:0];
    rd_ptr_d   = rd_ptr_q + (AW+1)'(load);
    len_rd_d   = len_rd_q + (LAW+1)'(pop);
    len_wr_d   = len_wr_q + (LAW+1)'(len_push);
  end

  // Buffer storage; contents need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (mem_we) data_mem[wr_ptr_q[AW-1:0]] <= wr_word;
    if (len_push) len_mem[len_wr_q[LAW-1:0]] <= len_entry;
  end

  // Pointers, registered full flags and the post-reset ready enable
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      commit_q      <= '0;
      rd_ptr_q      <= '0;
      len_wr_q      <= '0;
      len_rd_q      <= '0;
      frame_bytes_q <= '0;
      data_full_q   <= 1'b0;
      len_full_q    <= 1'b0;
      init_q        <= 1'b0;
`ifdef BEEHIVE_RX_FRAME_DROP_EN
      dropping_q    <= 1'b0;
      drop_cnt_q    <= '0;
`endif
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      commit_q      <= commit_d;
      rd_ptr_q      <= rd_ptr_d;
      len_wr_q      <= len_wr_d;
      len_rd_q      <= len_rd_d;
      frame_bytes_q <= frame_bytes_d;
      data_full_q   <= ((wr_ptr_d - rd_ptr_d) == (AW+1)'(DATA_FIFO_DEPTH));
      len_full_q    <= ((len_wr_d - len_rd_d) == (LAW+1)'(LEN_FIFO_DEPTH));
      init_q        <= 1'b1;
`ifdef BEEHIVE_RX_FRAME_DROP_EN
      dropping_q    <= dropping_d;
      drop_cnt_q    <= drop_cnt_d;
`endif
    end
  end

  // Read FSM with a one-entry registered output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      val_q       <= 1'b0;
      data_q      <= '0;
      start_q     <= 1'b0;
      end_q       <= 1'b0;
      size_q      <= '0;
      pad_q       <= '0;
      beats_q     <= '0;
      frame_pad_q <= '0;
    end else if (out_free) begin
      case (state_q)
        S_IDLE: begin
          if (!len_empty) begin
            val_q   <= 1'b1;
            data_q  <= rd_data;
            start_q <= 1'b1;
            size_q  <= head_size;
            if (head_beats <= SW'(1)) begin
              end_q <= 1'b1;
              pad_q <= head_pad;
            end else begin
              end_q       <= 1'b0;
              pad_q       <= '0;
              beats_q     <= head_beats - 1'b1;
              frame_pad_q <= head_pad;
              state_q     <= S_STREAM;
            end
          end else begin
            val_q   <= 1'b0;
            start_q <= 1'b0;
            end_q   <= 1'b0;
            size_q  <= '0;
            pad_q   <= '0;
          end
        end
        S_STREAM: begin
          val_q   <= 1'b1;
          data_q  <= rd_data;
          start_q <= 1'b0;
          size_q  <= '0;
          beats_q <= beats_q - 1'b1;
          if (beats_q == SW'(1)) begin
            end_q   <= 1'b1;
            pad_q   <= frame_pad_q;
            state_q <= S_IDLE;
          end else begin
            end_q <= 1'b0;
            pad_q <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign convert_dst_rx_val        = val_q;
  assign convert_dst_rx_data       = data_q;
  assign convert_dst_rx_startframe = start_q;
  assign convert_dst_rx_frame_size = size_q;
  assign convert_dst_rx_endframe   = end_q;
  assign convert_dst_rx_padbytes   = pad_q;

endmodule

// File: tb/tb_beehive_rx_frame_buffer.sv
// Directed testbench for beehive_rx_frame_buffer.
module tb_beehive_rx_frame_buffer;

`ifdef BEEHIVE_RX_FRAME_DROP_EN
  localparam int DD = 16;
`else
  localparam int DD = 64;
`endif

  typedef struct packed {
    logic [511:0] data;
    logic         s;
    logic         e;
    logic [15:0]  size;
    logic [5:0]   pad;
  } beat_t;

  logic         clk, rst;
  logic         tvalid, tready, tlast;
  logic [511:0] tdata;
  logic [63:0]  tkeep;
  logic [0:0]   tuser;
  logic         oval, rdy, ostart, oend;
  logic [511:0] odata;
  logic [15:0]  osize;
  logic [5:0]   opad;
  logic [31:0]  drop_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tlast_cyc = 0;
  int hold_viol = 0;
  int rd_idx = 0;
  beat_t rxq[$];
  beat_t cur_beat, held;
  logic hold_v = 1'b0;

  beehive_rx_frame_buffer #(
    .AXIS_SYNC_DATA_WIDTH(512), .AXIS_SYNC_KEEP_WIDTH(64),
    .AXIS_SYNC_RX_USER_WIDTH(1), .DATA_FIFO_DEPTH(DD), .LEN_FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .rst(rst),
    .app_axis_sync_rx_tvalid(tvalid), .app_axis_sync_rx_tready(tready),
    .app_axis_sync_rx_tdata(tdata), .app_axis_sync_rx_tkeep(tkeep),
    .app_axis_sync_rx_tlast(tlast), .app_axis_sync_rx_tuser(tuser),
    .convert_dst_rx_val(oval), .dst_convert_rx_rdy(rdy),
    .convert_dst_rx_data(odata), .convert_dst_rx_startframe(ostart),
    .convert_dst_rx_frame_size(osize), .convert_dst_rx_endframe(oend),
    .convert_dst_rx_padbytes(opad), .rx_drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign cur_beat = {odata, ostart, oend, osize, opad};

  // Output monitor: records transfers, watches hold stability, notes tlast cycle
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v && ({oval, cur_beat} !== {1'b1, held})) begin
        hold_viol++;
        $display("hold violation at cycle %0d", cyc);
      end
      hold_v = oval && !rdy;
      held   = cur_beat;
      if (oval && rdy) rxq.push_back(cur_beat);
      if (tvalid && tready && tlast) tlast_cyc = cyc;
    end
  end

  function automatic logic [7:0] pat(int f, int idx);
    return 8'(f * 37 + idx * 5 + 1);
  endfunction

  function automatic logic [511:0] in_word(int f, int k, int size);
    logic [511:0] w = '0;
    for (int j = 0; j < 64; j++)
      if (k * 64 + j < size) w[8*j +: 8] = pat(f, k * 64 + j);
    return w;
  endfunction

  function automatic logic [511:0] exp_word(int f, int k, int size);
    logic [511:0] w = '0;
    for (int j = 0; j < 64; j++)
      if (k * 64 + j < size) w[511-8*j -: 8] = pat(f, k * 64 + j);
    return w;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Drives beats of frame f; nsend=0 sends the whole frame, otherwise only nsend beats
  task automatic send_frame(input int f, input int size, input int nsend);
    int nb, rem, n;
    logic ok;
    logic [63:0] one;
    one = 64'd1;
    nb = (size + 63) / 64;
    if (nsend == 0) nsend = nb;
    for (int k = 0; k < nsend; k++) begin
      rem    = size - k * 64;
      tvalid = 1'b1;
      tdata  = in_word(f, k, size);
      tlast  = (k == nb - 1);
      tkeep  = (rem >= 64) ? '1 : ((one << rem) - 64'd1);
      n = 0;
      do begin
        @(negedge clk);
        ok = tready;
        tick();
        n++;
      end while (!ok && n < 3000);
      if (!ok) chk("tready_timeout", {511'd0, ok}, 512'd1);
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    tkeep  = '0;
    tdata  = '0;
  endtask

  task automatic wait_beats(input int target);
    int n = 0;
    do begin
      tick();
      n++;
    end while (rxq.size() < target && n < 4000);
    if (rxq.size() < target) chk("rx_beat_timeout", rxq.size(), target);
  endtask

  task automatic check_frame(input int f, input int size);
    int nb, pad;
    beat_t b;
    nb  = (size + 63) / 64;
    pad = nb * 64 - size;
    wait_beats(rd_idx + nb);
    for (int k = 0; k < nb; k++) begin
      b = (rd_idx < rxq.size()) ? rxq[rd_idx] : '0;
      chk($sformatf("f%0d_b%0d_data", f, k), b.data, exp_word(f, k, size));
      chk($sformatf("f%0d_b%0d_ctrl", f, k), {b.s, b.e, b.size, b.pad},
          {(k == 0), (k == nb - 1), 16'((k == 0) ? size : 0), 6'((k == nb - 1) ? pad : 0)});
      rd_idx++;
    end
  endtask

  initial begin
    int n, sent;
    rst = 1'b1; rdy = 1'b0; tvalid = 1'b0; tlast = 1'b0;
    tdata = '0; tkeep = '0; tuser = '0;
    repeat (3) tick();

    // Reset state
    @(negedge clk);
    chk("reset_tready", tready, 0);
    chk("reset_val", oval, 0);
    chk("reset_drop_cnt", drop_cnt, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("tready_cycle_of_release", tready, 0);
    tick();
    @(negedge clk);
    chk("tready_after_release", tready, 1);
    tick();

    // 60-byte single-beat frame, latency tlast -> val is 2 cycles
    rdy = 1'b1;
    send_frame(1, 60, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!oval && n < 20);
    chk("val_latency", cyc - tlast_cyc, 2);
    check_frame(1, 60);
    chk("drop_cnt_idle", drop_cnt, 0);

    // 128-byte frame in two full beats
    send_frame(2, 128, 0);
    check_frame(2, 128);

`ifndef BEEHIVE_RX_FRAME_DROP_EN
    // Three back-to-back 1500-byte frames with rdy toggling each cycle
    fork
      begin
        send_frame(3, 1500, 0);
        send_frame(4, 1500, 0);
        send_frame(5, 1500, 0);
      end
      begin
        int m = 0;
        while (rxq.size() < rd_idx + 72 && m < 4000) begin
          @(posedge clk);
          #2;
          rdy = ~rdy;
          m++;
        end
      end
    join
    rdy = 1'b1;
    check_frame(3, 1500);
    check_frame(4, 1500);
    check_frame(5, 1500);
`endif

    // rdy low: length FIFO (8) plus output register (1) hold 9 frames, then tready drops
    rdy = 1'b0;
    tick();
    sent = 0;
    for (int i = 0; i < 12; i++) begin
      if (!tready) break;
      send_frame(10 + i, 40 + i, 0);
      sent++;
    end
    chk("frames_accepted_before_full", sent, 9);
    repeat (5) tick();
    chk("tready_low_when_full", tready, 0);
    chk("no_output_while_rdy_low", rxq.size(), rd_idx);
    rdy = 1'b1;
    for (int i = 0; i < sent; i++) check_frame(10 + i, 40 + i);
    send_frame(30, 200, 0);
    check_frame(30, 200);

    // Reset mid-frame after 10 beats, then a 64-byte frame
    send_frame(40, 1500, 10);
    repeat (4) tick();
    chk("partial_no_output", rxq.size(), rd_idx);
    rst = 1'b1;
    tick();
    tick();
    chk("tready_in_reset", tready, 0);
    chk("val_in_reset", oval, 0);
    rst = 1'b0;
    tick();
    tick();
    send_frame(41, 64, 0);
    check_frame(41, 64);
    repeat (5) tick();
    chk("no_stray_after_reset", rxq.size(), rd_idx);

`ifdef BEEHIVE_RX_FRAME_DROP_EN
    // 20-beat frame into a 16-beat RAM with rdy low is dropped
    rdy = 1'b0;
    send_frame(50, 1280, 0);
    repeat (4) tick();
    chk("drop_cnt_after_overflow", drop_cnt, 1);
    chk("dropped_frame_no_val", oval, 0);
    send_frame(51, 100, 0);
    rdy = 1'b1;
    check_frame(51, 100);
    chk("no_stray_after_drop", rxq.size(), rd_idx);
`endif

    chk("output_hold_stability", hold_viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
